// File: rtl/sfp_array.sv
// Multi-channel special-function processor: per-column saturating accumulators,
// a one-cycle activation pass, and a serial valid/ready drain that clears the tile.
module sfp_array #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int leak_sh = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*bw-1:0]        in,
  input  logic                     acc,
  input  logic                     act_go,
  input  logic [1:0]               act_mode,
  input  logic [psum_bw-1:0]       thres,
  input  logic                     drain,
  output logic [psum_bw-1:0]       out,
  output logic [$clog2(col)-1:0]   out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   psum_bus,
  output logic                     busy,
  output logic                     sat
);

  localparam int CW = $clog2(col);
  localparam logic signed [psum_bw-1:0] SMAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] SMIN = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACT, DRAIN} state_t;

  state_t                     state_q;
  logic signed [psum_bw-1:0]  psum_q [col];
  logic signed [psum_bw:0]    sum_d  [col];
  logic signed [psum_bw-1:0]  acc_d  [col];
  logic signed [psum_bw-1:0]  act_d  [col];
  logic [col-1:0]             clip_d;
  logic [1:0]                 mode_q;
  logic signed [psum_bw-1:0]  thres_q;
  logic [CW-1:0]              out_ch_q;
  logic                       sat_q;

  // One guard bit catches overflow: the top two sum bits disagree exactly when clamping is needed.
  always_comb begin
    for (int k = 0; k < col; k++) begin
      sum_d[k]  = $signed({psum_q[k][psum_bw-1], psum_q[k]})
                + $signed({{(psum_bw+1-bw){in[k*bw+bw-1]}}, in[k*bw +: bw]});
      clip_d[k] = sum_d[k][psum_bw] ^ sum_d[k][psum_bw-1];
      if (clip_d[k]) acc_d[k] = sum_d[k][psum_bw] ? SMIN : SMAX;
      else           acc_d[k] = sum_d[k][psum_bw-1:0];
      act_d[k] = psum_q[k];
      case (mode_q)
        2'd1:    if (psum_q[k] < thres_q) act_d[k] = '0;
        2'd2:    if (psum_q[k][psum_bw-1]) act_d[k] = psum_q[k] >>> leak_sh;
        2'd3:    if (psum_q[k] < thres_q) act_d[k] = thres_q;
        default: act_d[k] = psum_q[k];
      endcase
    end
  end

  always_comb begin
    psum_bus = '0;
    for (int k = 0; k < col; k++) psum_bus[k*psum_bw +: psum_bw] = psum_q[k];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      out_ch_q <= '0;
      sat_q    <= 1'b0;
      mode_q   <= '0;
      thres_q  <= '0;
      for (int k = 0; k < col; k++) psum_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            for (int k = 0; k < col; k++) psum_q[k] <= acc_d[k];
            if (|clip_d) sat_q <= 1'b1;
          end else if (act_go) begin
            mode_q  <= act_mode;
            thres_q <= thres;
            state_q <= ACT;
          end else if (drain) begin
            out_ch_q <= '0;
            state_q  <= DRAIN;
          end
        end
        ACT: begin
          for (int k = 0; k < col; k++) psum_q[k] <= act_d[k];
          state_q <= IDLE;
        end
        DRAIN: begin
          // Final handshake wipes the tile so the next one starts from zero.
          if (out_ready) begin
            if (out_ch_q == CW'(col-1)) begin
              for (int k = 0; k < col; k++) psum_q[k] <= '0;
              sat_q    <= 1'b0;
              out_ch_q <= '0;
              state_q  <= IDLE;
            end else begin
              out_ch_q <= out_ch_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = psum_q[out_ch_q];
  assign out_ch    = out_ch_q;
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign sat       = sat_q;

endmodule

// File: doc/sfp_array.md
Name: sfp_array

Overview:
- Multi-channel special-function processor at the bottom of the PE array.
- Each of `col` channels accumulates signed partial sums from its column output.
- On command, applies a selectable activation (bypass, thresholded ReLU, leaky, clamp) to all channels in one cycle.
- Drains results serially over a valid/ready handshake, then self-clears for the next tile.

Parameters:
- bw, 4: width of each signed per-channel input.
- psum_bw, 16: width of each signed accumulator and of the output.
- col, 8: number of channels (at least 2).
- leak_sh, 2: arithmetic right-shift amount for leaky mode.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in  input  col*bw  packed signed inputs; channel k at [k*bw +: bw].
- acc  input  1  accumulate strobe.
- act_go  input  1  apply activation once.
- act_mode  input  2  0 bypass, 1 thresholded ReLU, 2 leaky, 3 clamp; sampled with act_go.
- thres  input  psum_bw  signed threshold; sampled with act_go.
- drain  input  1  start serial readout.
- out  output  psum_bw  signed accumulator of the channel selected by out_ch.
- out_ch  output  $clog2(col)  channel index being presented.
- out_valid  output  1  out/out_ch valid.
- out_ready  input  1  consumer accepts.
- psum_bus  output  col*psum_bw  parallel view of all accumulators.
- busy  output  1  high in ACT or DRAIN.
- sat  output  1  sticky: some accumulate saturated since last clear.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All accumulators 0, state IDLE, out_ch 0, sat 0.
  - out_valid 0, busy 0.
  - Reset applies in any state, including mid-DRAIN; a partial drain is abandoned.
- State machine: IDLE, ACT, DRAIN.
- IDLE command priority is acc > act_go > drain.
  - Lower-priority commands asserted in the same cycle are dropped, not queued.
- acc in IDLE:
  - Each channel: psum_k <= sat(psum_k + sign_ext(in_k)).
  - Result visible on psum_bus the next cycle (1-cycle latency).
  - Stays in IDLE.
- Saturation: results clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. Any clamping channel sets sat in the same update.
- act_go in IDLE: latch act_mode and thres, go to ACT.
- ACT lasts exactly one cycle and updates every channel simultaneously:
  - Mode 0: unchanged.
  - Mode 1: psum < thres -> 0, else unchanged.
  - Mode 2: psum < 0 -> psum >>> leak_sh (arithmetic, floor), else unchanged.
  - Mode 3: psum < thres -> thres, else unchanged.
  - All comparisons are signed. Next state is IDLE.
  - act_go may be issued repeatedly; each applies again to the current values.
- drain in IDLE: out_ch <= 0, go to DRAIN.
- DRAIN:
  - out_valid = 1; out = psum[out_ch] (combinational mux of registered accumulators).
  - out and out_ch hold stable while out_ready==0.
  - Handshake = out_valid & out_ready. Each handshake increments out_ch.
  - Handshake at out_ch == col-1: all accumulators cleared to 0, sat cleared, out_ch <= 0, state IDLE. out_valid is 0 the next cycle.
  - Throughput is 1 channel/cycle with out_ready held high, so a full drain takes col cycles.
- busy = (state != IDLE). acc, act_go and drain are ignored while busy; no side effects.
- out_valid is 0 outside DRAIN; out then shows psum[out_ch] and is don't-care.
- in, thres and act_mode are don't-care except on the cycle they are sampled.

Test Plan:
- Accumulate:
  - Reset, then 3 acc cycles with every channel in=+5, then ch0 in=-8 for 1 acc cycle.
  - Expect psum_bus ch0 = 7, others 15, sat=0.
- Saturation, with psum_bw=16:
  - Preload ch1 to 32764 via accumulates, then acc with in=+7.
  - Expect ch1 = 32767 and sat=1.
  - Symmetric check: negative clamp to -32768.
- Activation modes, with ch0..ch3 = -7, -1, 3, 10 and thres=3:
  - Mode 1 -> 0, 0, 3, 10.
  - Separate load, mode 2 -> -2, -1, 3, 10.
  - Separate load, mode 3 -> 3, 3, 3, 10.
  - busy is high exactly 1 cycle.
- Drain with backpressure:
  - col=8; toggle out_ready 1, 0, 1, ...
  - Expect out_ch 0..7 in order, values stable while out_ready=0, exactly 8 handshakes.
  - After the last handshake: accumulators 0, sat 0, busy 0.
- Command collision and ignore:
  - acc+act_go+drain in the same IDLE cycle -> only the accumulate takes effect.
  - acc during DRAIN -> no change to psum_bus.
- Reset mid-drain:
  - Assert reset after 3 handshakes.
  - Next cycle: out_valid 0, out_ch 0, all accumulators 0, state IDLE.
  - A subsequent drain restarts at ch0.
